// File: rtl/paging_unit.sv
// rtl/paging_unit.sv - 80386-style two-level page translation with a fully associative TLB
module paging_unit #(
    parameter int TLB_ENTRIES = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        paging_enable,
    input  logic [19:0] cr3_base,
    input  logic        tlb_flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_linear_address,
    input  logic        req_write,
    input  logic        req_user,
    output logic        rsp_valid,
    output logic [31:0] rsp_physical_address,
    output logic        rsp_fault,
    output logic [2:0]  rsp_fault_code,
    output logic        mem_req,
    output logic [31:0] mem_address,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);
    localparam int IW = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE, PDE_READ, PTE_READ, RESPOND} state_t;

    state_t                 state_q, state_d;
    logic [31:0]            lin_q, lin_d;
    logic                   write_q, write_d, user_q, user_d;
    logic [19:0]            pde_pfn_q, pde_pfn_d;
    logic                   pde_u_q, pde_u_d, pde_w_q, pde_w_d;
    logic                   flushed_q, flushed_d;
    logic [TLB_ENTRIES-1:0] valid_q, valid_d, u_q, u_d, w_q, w_d;
    logic [19:0]            vpn_q [TLB_ENTRIES];
    logic [19:0]            vpn_d [TLB_ENTRIES];
    logic [19:0]            pfn_q [TLB_ENTRIES];
    logic [19:0]            pfn_d [TLB_ENTRIES];
    logic [IW-1:0]          ptr_q, ptr_d;
    logic                   ready_q, ready_d, rsp_valid_q, rsp_valid_d, fault_q, fault_d;
    logic [31:0]            pa_q, pa_d, mem_addr_q, mem_addr_d;
    logic [2:0]             code_q, code_d;
    logic                   mem_req_q, mem_req_d;

    logic                   hit, found_free, fill, prot, eff_u, eff_w;
    logic [IW-1:0]          hit_idx, victim;
    logic                   unused_pte_bits;

    assign unused_pte_bits = ^mem_data[11:3];

    // A user access faults on a supervisor page or on a write to a read-only page.
    function automatic logic prot_fault(input logic user, input logic write,
                                        input logic u, input logic w);
        return user & (~u | (write & ~w));
    endfunction

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        found_free = 1'b0;
        victim     = ptr_q;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (valid_q[i] && vpn_q[i] == req_linear_address[31:12]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                found_free = 1'b1;
                victim     = IW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lin_d       = lin_q;
        write_d     = write_q;
        user_d      = user_q;
        pde_pfn_d   = pde_pfn_q;
        pde_u_d     = pde_u_q;
        pde_w_d     = pde_w_q;
        flushed_d   = flushed_q | tlb_flush;
        valid_d     = valid_q;
        u_d         = u_q;
        w_d         = w_q;
        vpn_d       = vpn_q;
        pfn_d       = pfn_q;
        ptr_d       = ptr_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        fault_d     = fault_q;
        pa_d        = pa_q;
        code_d      = code_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fill        = 1'b0;
        prot        = 1'b0;
        eff_u       = 1'b0;
        eff_w       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lin_d     = req_linear_address;
                    write_d   = req_write;
                    user_d    = req_user;
                    flushed_d = tlb_flush;
                    ready_d   = 1'b0;
                    if (!paging_enable) begin
                        state_d     = RESPOND;
                        rsp_valid_d = 1'b1;
                        pa_d        = req_linear_address;
                        fault_d     = 1'b0;
                        code_d      = 3'b000;
                    end else if (hit) begin
                        prot        = prot_fault(req_user, req_write, u_q[hit_idx], w_q[hit_idx]);
                        state_d     = RESPOND;
                        rsp_valid_d = 1'b1;
                        pa_d        = prot ? 32'h0 : {pfn_q[hit_idx], req_linear_address[11:0]};
                        fault_d     = prot;
                        code_d      = {req_user, req_write, prot};
                    end else begin
                        state_d    = PDE_READ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {cr3_base, req_linear_address[31:22], 2'b00};
                    end
                end
            end
            PDE_READ: begin
                if (mem_ack) begin
                    if (!mem_data[0]) begin
                        state_d     = RESPOND;
                        mem_req_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        pa_d        = 32'h0;
                        fault_d     = 1'b1;
                        code_d      = {user_q, write_q, 1'b0};
                    end else begin
                        state_d    = PTE_READ;
                        pde_pfn_d  = mem_data[31:12];
                        pde_u_d    = mem_data[2];
                        pde_w_d    = mem_data[1];
                        mem_addr_d = {mem_data[31:12], lin_q[21:12], 2'b00};
                    end
                end
            end
            PTE_READ: begin
                if (mem_ack) begin
                    state_d     = RESPOND;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (!mem_data[0]) begin
                        pa_d    = 32'h0;
                        fault_d = 1'b1;
                        code_d  = {user_q, write_q, 1'b0};
                    end else begin
                        eff_u   = pde_u_q & mem_data[2];
                        eff_w   = pde_w_q & mem_data[1];
                        prot    = prot_fault(user_q, write_q, eff_u, eff_w);
                        pa_d    = prot ? 32'h0 : {mem_data[31:12], lin_q[11:0]};
                        fault_d = prot;
                        code_d  = {user_q, write_q, prot};
                        // Hits recheck permissions, so faulting walks still fill.
                        fill    = ~flushed_q;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (fill) begin
            valid_d[victim] = 1'b1;
            vpn_d[victim]   = lin_q[31:12];
            pfn_d[victim]   = mem_data[31:12];
            u_d[victim]     = eff_u;
            w_d[victim]     = eff_w;
            if (!found_free) ptr_d = ptr_q + IW'(1);
        end
        if (tlb_flush) valid_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lin_q       <= '0;
            write_q     <= 1'b0;
            user_q      <= 1'b0;
            pde_pfn_q   <= '0;
            pde_u_q     <= 1'b0;
            pde_w_q     <= 1'b0;
            flushed_q   <= 1'b0;
            valid_q     <= '0;
            u_q         <= '0;
            w_q         <= '0;
            vpn_q       <= '{default: '0};
            pfn_q       <= '{default: '0};
            ptr_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            pa_q        <= '0;
            code_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            lin_q       <= lin_d;
            write_q     <= write_d;
            user_q      <= user_d;
            pde_pfn_q   <= pde_pfn_d;
            pde_u_q     <= pde_u_d;
            pde_w_q     <= pde_w_d;
            flushed_q   <= flushed_d;
            valid_q     <= valid_d;
            u_q         <= u_d;
            w_q         <= w_d;
            vpn_q       <= vpn_d;
            pfn_q       <= pfn_d;
            ptr_q       <= ptr_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            fault_q     <= fault_d;
            pa_q        <= pa_d;
            code_q      <= code_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign req_ready            = ready_q;
    assign rsp_valid            = rsp_valid_q;
    assign rsp_physical_address = pa_q;
    assign rsp_fault            = fault_q;
    assign rsp_fault_code       = code_q;
    assign mem_req              = mem_req_q;
    assign mem_address          = mem_addr_q;
endmodule

// File: doc/paging_unit.md
# paging_unit

Translates 32-bit linear addresses from the segmentation stage into physical addresses for the bus interface, following the 80386 two-level paging scheme (4 KiB pages, page directory plus page table). It holds a small fully associative TLB, walks the PDE and PTE through a memory read handshake on a miss, and checks U/S and R/W permissions. With paging disabled it passes the linear address through with the same latency as a TLB hit.

## Interface
Parameters:
- TLB_ENTRIES, 8, number of fully associative TLB entries (power of two, 2..32)

Ports:
- clock  input  1  single clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- paging_enable  input  1  CR0.PG; sampled at request accept
- cr3_base  input  20  page directory base (CR3[31:12]); sampled at request accept
- tlb_flush  input  1  invalidate all TLB entries (CR3 load)
- req_valid  input  1  translation request
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_linear_address  input  32  linear address
- req_write  input  1  1 = write access
- req_user  input  1  1 = CPL 3 access
- rsp_valid  output  1  one-cycle response pulse
- rsp_physical_address  output  32  translated address
- rsp_fault  output  1  page fault
- rsp_fault_code  output  3  {U/S, W/R, P}, 80386 error code bits 2:0
- mem_req  output  1  page-structure read request
- mem_address  output  32  dword address of PDE/PTE
- mem_ack  input  1  read complete; mem_data valid this cycle
- mem_data  input  32  PDE/PTE contents

## Operation
- States: IDLE, PDE_READ, PTE_READ, RESPOND.
- IDLE: req_ready=1. When req_valid=1, capture address, write, user, paging_enable and cr3_base.
- Paging disabled: go to RESPOND with physical address equal to the linear address and no fault.
- Paging enabled: compare linear[31:12] against all valid entries.
  - Hit: go to RESPOND and check permissions using the entry's U and W.
  - Miss: go to PDE_READ.
- PDE_READ: mem_req=1, mem_address={cr3_base, linear[31:22], 2'b00}. On mem_ack, latch the PDE.
  - If PDE[0]=0, raise a not-present fault and go to RESPOND.
  - Otherwise go to PTE_READ.
- PTE_READ: mem_req=1, mem_address={PDE[31:12], linear[21:12], 2'b00}. On mem_ack:
  - If PTE[0]=0, raise a not-present fault.
  - Otherwise U = PDE[2] & PTE[2], W = PDE[1] & PTE[1]. Check permissions, fill the TLB and go to RESPOND.
- Permission fault rules:
  - User access with U=0 is a fault.
  - User write with W=0 is a fault.
  - Supervisor accesses never take a protection fault (80386 rule).
- Fault code bits:
  - Bit0 = 1 for a protection violation, 0 for not-present.
  - Bit1 = req_write.
  - Bit2 = req_user.
- Fill rules:
  - The TLB is filled only on a walk with no not-present fault. A fill on a protection-faulting walk is allowed, because permissions are rechecked on a hit.
  - Victim is the lowest-index invalid entry. If all entries are valid, the victim is replace_ptr, which then increments modulo TLB_ENTRIES.
- Physical address is {PFN, linear[11:0]}. When faulting, rsp_physical_address=0.
- Accessed and dirty bits are not written back by this block.
- RESPOND: rsp_valid=1 for exactly one cycle, then return to IDLE. There is no response backpressure.
- tlb_flush clears all valid bits on the next edge, in any state.
  - If asserted during a walk, the walk completes and responds but its fill is suppressed.
  - If flush and fill land in the same cycle, flush wins.
  - replace_ptr is unchanged by a flush.

## Timing
- Reset values:
  - State is IDLE and all valid bits are 0.
  - replace_ptr=0 and req_ready=1.
  - rsp_valid, rsp_fault, rsp_fault_code, rsp_physical_address, mem_req and mem_address are all 0.
- Reset mid-walk abandons the walk; mem_req drops asynchronously.
- Hit or paging disabled: accept at cycle N, rsp_valid at N+1, req_ready back to 1 at N+2. Throughput is one request per 2 cycles.
- Miss with zero-wait memory (mem_ack in the first cycle of each read):
  - PDE read at N+1, PTE read at N+2, rsp_valid at N+3.
  - Each wait cycle adds one cycle of latency.
- A PDE not-present fault responds on the cycle after the PDE ack.
- Memory handshake:
  - mem_req and mem_address are registered and held stable until mem_ack.
  - mem_ack is ignored while mem_req=0.
  - mem_req deasserts the cycle after ack, except when going PDE→PTE, where it stays high with the new address.
- All outputs are registered.

## Test plan
- Paging off, linear 0x1234_5678 → rsp_valid at N+1, phys 0x1234_5678, fault 0, no mem_req.
- Paging on, cr3_base 0x00010, linear 0x0040_3ABC, PDE 0x0002_0007, PTE 0x0005_5007, zero-wait:
  - Reads at 0x0001_0004 then 0x0002_000C.
  - rsp_valid at N+3 with phys 0x0005_5ABC.
  - Repeating the request hits, responds at N+1 with no mem_req.
- PDE 0x0002_0006 (not present), user read → fault 1, code 3'b100, TLB not filled.
- User write with PDE W=1 and PTE 0x0005_5005 (W=0) → fault code 3'b111.
  - The same write as supervisor → no fault.
- Fill 9 distinct pages with TLB_ENTRIES=8 → the ninth replaces entry 0, so page 1 misses and its refill replaces entry 1.
- tlb_flush during PTE_READ → response correct, next same-page request walks again; reset mid-walk → mem_req 0 immediately, req_ready 1.
